// File: rtl/zap_fifo_pkg.sv
// Shared types and helpers for the zap synchronous FIFO.
package zap_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Pointer width: one extra bit over the address so full and empty never alias.
  function automatic int unsigned ptr_wdt(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/zap_fifo_ram.sv
// DEPTH x WIDTH simple dual-port RAM with a registered, unreset read port.
module zap_fifo_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read returns the pre-write contents on an address collision.
  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/zap_sync_fifo_lvl.sv
// Single-clock FIFO with occupancy count, level flags, flush and sticky error flags.
module zap_sync_fifo_lvl
  import zap_fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned FWFT   = 1,
  parameter int unsigned AF_LVL = 14,
  parameter int unsigned AE_LVL = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_flush,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_almost_full,
  output logic                       o_almost_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow,
  output logic                       o_underflow,
  input  logic                       i_clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_wdt(DEPTH);
  localparam fifo_mode_e  MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q, wr_ptr_nx, rd_ptr_nx, count_nx;
  logic             readable, wr_acc, rd_acc, ovf_new, udf_new;
  logic             ram_re, bypass, valid_nx;
  logic [AW-1:0]    ram_raddr;
  logic [WIDTH-1:0] ram_rdata, hold_q, hold_d;
  logic             sel_ram_q, sel_ram_d;

  // Accept/pop qualification; flush swallows both and raises no errors.
  always_comb begin
    readable  = (MODE == FIFO_FWFT) ? o_valid : !o_empty;
    wr_acc    = !i_flush && i_wr_en && !o_full;
    rd_acc    = !i_flush && i_rd_en && readable;
    ovf_new   = !i_flush && i_wr_en && o_full;
    udf_new   = !i_flush && i_rd_en && !readable;
    wr_ptr_nx = i_flush ? '0 : wr_ptr_q + PW'(wr_acc);
    rd_ptr_nx = i_flush ? '0 : rd_ptr_q + PW'(rd_acc);
    count_nx  = wr_ptr_nx - rd_ptr_nx;
    valid_nx  = (MODE == FIFO_FWFT) ? (count_nx != '0) : rd_acc;
  end

  // FWFT prefetches the next head every cycle; a write landing on that head bypasses the RAM.
  always_comb begin
    ram_re    = (MODE == FIFO_FWFT) ? 1'b1 : rd_acc;
    ram_raddr = (MODE == FIFO_FWFT) ? rd_ptr_nx[AW-1:0] : rd_ptr_q[AW-1:0];
    bypass    = (MODE == FIFO_FWFT) && wr_acc && (wr_ptr_q[AW-1:0] == rd_ptr_nx[AW-1:0]);
  end

  // o_data source: RAM read register, or a hold register that keeps the last shown word.
  always_comb begin
    hold_d    = hold_q;
    sel_ram_d = sel_ram_q;
    if (i_flush) begin
      sel_ram_d = 1'b0;
      hold_d    = o_data;
    end else if (MODE == FIFO_FWFT) begin
      if (bypass) begin
        sel_ram_d = 1'b0;
        hold_d    = i_data;
      end else if (count_nx == '0) begin
        sel_ram_d = 1'b0;
        hold_d    = o_data;
      end else begin
        sel_ram_d = 1'b1;
      end
    end else if (rd_acc) begin
      sel_ram_d = 1'b1;
    end
  end

  assign o_data = sel_ram_q ? ram_rdata : hold_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      o_count        <= '0;
      o_empty        <= 1'b1;
      o_full         <= 1'b0;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
      o_valid        <= 1'b0;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
      hold_q         <= '0;
      sel_ram_q      <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_nx;
      rd_ptr_q       <= rd_ptr_nx;
      o_count        <= count_nx;
      o_empty        <= (count_nx == '0);
      o_full         <= (count_nx == PW'(DEPTH));
      o_almost_full  <= (count_nx >= PW'(AF_LVL));
      o_almost_empty <= (count_nx <= PW'(AE_LVL));
      o_valid        <= valid_nx;
      o_overflow     <= (o_overflow && !i_clr_err) || ovf_new;
      o_underflow    <= (o_underflow && !i_clr_err) || udf_new;
      hold_q         <= hold_d;
      sel_ram_q      <= sel_ram_d;
    end
  end

  zap_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk (i_clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (i_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_zap_sync_fifo_lvl.sv
// Bench for zap_sync_fifo_lvl: STD and FWFT instances share stimulus, each checked against a queue model.
module tb_zap_sync_fifo_lvl;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned AF = 3;
  localparam int unsigned AE = 1;

  logic         clk;
  logic         rst_n;
  logic         flush, wr_en, rd_en, clr_err;
  logic [W-1:0] din;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar m = 0; m < 2; m++) begin : g_dut
    logic [W-1:0] d_data;
    logic         d_valid, d_empty, d_full, d_af, d_ae, d_ovf, d_udf;
    logic [2:0]   d_count;

    zap_sync_fifo_lvl #(
      .WIDTH (W), .DEPTH (D), .FWFT (m), .AF_LVL (AF), .AE_LVL (AE)
    ) dut (
      .i_clk          (clk),
      .i_reset_n      (rst_n),
      .i_flush        (flush),
      .i_wr_en        (wr_en),
      .i_data         (din),
      .i_rd_en        (rd_en),
      .o_data         (d_data),
      .o_valid        (d_valid),
      .o_empty        (d_empty),
      .o_full         (d_full),
      .o_almost_full  (d_af),
      .o_almost_empty (d_ae),
      .o_count        (d_count),
      .o_overflow     (d_ovf),
      .o_underflow    (d_udf),
      .i_clr_err      (clr_err)
    );

    // Behavioural model: a queue of accepted words plus the word last presented.
    logic [W-1:0] mq [$];
    logic [W-1:0] m_data;
    logic         m_valid, m_ovf, m_udf;

    initial begin
      mq.delete();
      m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          mq.delete();
          m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else if (flush) begin
          mq.delete();
          m_valid = 1'b0;
          if (clr_err) begin m_ovf = 1'b0; m_udf = 1'b0; end
        end else begin
          bit full_now, can_read, push, pop;
          full_now = (mq.size() == D);
          can_read = (mq.size() > 0);
          push = wr_en && !full_now;
          pop  = rd_en && can_read;
          m_ovf = (m_ovf && !clr_err) || (wr_en && full_now);
          m_udf = (m_udf && !clr_err) || (rd_en && !can_read);
          if (m == 0) begin
            if (pop) m_data = mq[0];
            m_valid = pop;
          end
          if (pop) void'(mq.pop_front());
          if (push) mq.push_back(din);
          if (m == 1) begin
            m_valid = (mq.size() > 0);
            if (m_valid) m_data = mq[0];
          end
        end
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        chk($sformatf("m%0d count", m), int'(d_count), mq.size());
        chk($sformatf("m%0d empty", m), int'(d_empty), int'(mq.size() == 0));
        chk($sformatf("m%0d full", m), int'(d_full), int'(mq.size() == D));
        chk($sformatf("m%0d afull", m), int'(d_af), int'(mq.size() >= AF));
        chk($sformatf("m%0d aempty", m), int'(d_ae), int'(mq.size() <= AE));
        chk($sformatf("m%0d valid", m), int'(d_valid), int'(m_valid));
        chk($sformatf("m%0d data", m), int'(d_data), int'(m_data));
        chk($sformatf("m%0d ovf", m), int'(d_ovf), int'(m_ovf));
        chk($sformatf("m%0d udf", m), int'(d_udf), int'(m_udf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("reset count", int'(g_dut[1].d_count), 0);
    chk("reset empty", int'(g_dut[1].d_empty), 1);
    chk("reset aempty", int'(g_dut[0].d_ae), 1);
    chk("reset data", int'(g_dut[0].d_data), 0);

    // Write into empty: FWFT head visible one edge later.
    wr_en = 1'b1; din = 8'h11;
    tick();
    wr_en = 1'b0;
    chk("t1 fwft valid", int'(g_dut[1].d_valid), 1);
    chk("t1 fwft data", int'(g_dut[1].d_data), 8'h11);
    chk("t1 count", int'(g_dut[1].d_count), 1);
    chk("t1 empty", int'(g_dut[1].d_empty), 0);
    chk("t1 aempty", int'(g_dut[1].d_ae), 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t1 std valid", int'(g_dut[0].d_valid), 1);
    chk("t1 std data", int'(g_dut[0].d_data), 8'h11);
    chk("t1 fwft count", int'(g_dut[1].d_count), 0);

    // Fill, overflow, drain in order.
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; din = 8'(i);
      tick();
    end
    chk("t2 full", int'(g_dut[1].d_full), 1);
    chk("t2 count", int'(g_dut[1].d_count), 4);
    chk("t2 afull", int'(g_dut[1].d_af), 1);
    din = 8'h05;
    tick();
    wr_en = 1'b0;
    chk("t2 ovf fwft", int'(g_dut[1].d_ovf), 1);
    chk("t2 ovf std", int'(g_dut[0].d_ovf), 1);
    chk("t2 count kept", int'(g_dut[0].d_count), 4);
    rd_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t2 fwft order", int'(g_dut[1].d_data), i);
      tick();
    end
    rd_en = 1'b0;
    chk("t2 empty", int'(g_dut[1].d_empty), 1);
    chk("t2 std last", int'(g_dut[0].d_data), 8'h04);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // Pointer wrap: 10 x (3 writes, 3 pops).
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < 3; k++) begin
        wr_en = 1'b1; din = 8'(8'h40 + it * 3 + k);
        tick();
      end
      wr_en = 1'b0;
      chk("t3 count", int'(g_dut[1].d_count), 3);
      rd_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
        chk("t3 order", int'(g_dut[1].d_data), 8'h40 + it * 3 + k);
        tick();
      end
      rd_en = 1'b0;
    end
    chk("t3 count end", int'(g_dut[0].d_count), 0);

    // Full with simultaneous write and pop: pop wins, write dropped.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; din = 8'(8'h20 + i);
      tick();
    end
    rd_en = 1'b1; din = 8'h99;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("t4 count", int'(g_dut[1].d_count), 3);
    chk("t4 ovf", int'(g_dut[1].d_ovf), 1);
    chk("t4 head", int'(g_dut[1].d_data), 8'h21);
    chk("t4 std data", int'(g_dut[0].d_data), 8'h20);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t4 clr", int'(g_dut[1].d_ovf), 0);
    rd_en = 1'b1;
    repeat (3) tick();
    rd_en = 1'b0;

    // STD read latency, then underflow on empty.
    wr_en = 1'b1; din = 8'hA5;
    tick();
    wr_en = 1'b0;
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t5 std valid", int'(g_dut[0].d_valid), 1);
    chk("t5 std data", int'(g_dut[0].d_data), 8'hA5);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t5 udf std", int'(g_dut[0].d_udf), 1);
    chk("t5 udf fwft", int'(g_dut[1].d_udf), 1);
    chk("t5 std valid off", int'(g_dut[0].d_valid), 0);

    // Flush with same-cycle write/read, then async reset mid-burst.
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; din = 8'(8'h31 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("t6 count", int'(g_dut[1].d_count), 3);
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 8'h77;
    tick();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("t6 flush count", int'(g_dut[1].d_count), 0);
    chk("t6 flush valid", int'(g_dut[1].d_valid), 0);
    chk("t6 flush empty", int'(g_dut[0].d_empty), 1);
    chk("t6 flush ovf", int'(g_dut[1].d_ovf), 0);
    chk("t6 flush udf", int'(g_dut[1].d_udf), 0);
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; din = 8'(8'h50 + i);
      tick();
    end
    chk("t6 pre-reset ovf", int'(g_dut[1].d_ovf), 1);
    #1 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      logic [7:0] d; logic v, e, f, af, ae, ov; logic [2:0] c;
      if (m == 0) begin
        d = g_dut[0].d_data; v = g_dut[0].d_valid; e = g_dut[0].d_empty; f = g_dut[0].d_full;
        af = g_dut[0].d_af; ae = g_dut[0].d_ae; ov = g_dut[0].d_ovf; c = g_dut[0].d_count;
      end else begin
        d = g_dut[1].d_data; v = g_dut[1].d_valid; e = g_dut[1].d_empty; f = g_dut[1].d_full;
        af = g_dut[1].d_af; ae = g_dut[1].d_ae; ov = g_dut[1].d_ovf; c = g_dut[1].d_count;
      end
      chk($sformatf("t6 arst m%0d count", m), int'(c), 0);
      chk($sformatf("t6 arst m%0d empty", m), int'(e), 1);
      chk($sformatf("t6 arst m%0d full", m), int'(f), 0);
      chk($sformatf("t6 arst m%0d afull", m), int'(af), 0);
      chk($sformatf("t6 arst m%0d aempty", m), int'(ae), 1);
      chk($sformatf("t6 arst m%0d valid", m), int'(v), 0);
      chk($sformatf("t6 arst m%0d data", m), int'(d), 0);
      chk($sformatf("t6 arst m%0d ovf", m), int'(ov), 0);
    end
    tick();
    rst_n = 1'b1; wr_en = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
